// File: rtl/stream_mux_n_if.sv
// Stream mux bundle: channel select, N input streams, one output stream, status.
// Latency: n/a (wiring only).
// Backpressure: in_ready and out_ready carry the valid/ready handshakes.
// Ports: slave = mux side, master = producer/consumer side.
//   sel, in_data/in_valid/in_last  -> mux;  in_ready            <- mux
//   out_ready                      -> mux;  out_data/valid/last <- mux
//   active_ch, busy, sel_err       <- mux (status)
interface stream_mux_n_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int SELW = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;

    logic [SELW-1:0]       sel;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic [SELW-1:0]       active_ch;
    logic                  busy;
    logic                  sel_err;

    modport slave (
        input  sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, active_ch, busy, sel_err
    );

    modport master (
        output sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, active_ch, busy, sel_err
    );
endinterface

// File: rtl/stream_mux_n.sv
// Packet-locked N:1 stream mux with a registered output stage.
// Latency: lock -> accept next cycle -> out_valid the cycle after; 1 beat/clk inside a packet.
// Backpressure: out_valid && !out_ready holds the output and drops in_ready of the locked channel.
// Ports: clk, rst (async, active-high); bus = stream_mux_n_if.slave (see interface file).
// Optional: define STREAM_MUX_RR_ARB_EN for round-robin channel choice (sel ignored, sel_err = 0).
module stream_mux_n #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    stream_mux_n_if.slave bus
);
    localparam int SELW = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state;
    logic [SELW-1:0]   active_ch;
    logic [WIDTH-1:0]  out_data_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              sel_err_r;

    logic [WIDTH-1:0]  ch_data;
    logic              ch_valid;
    logic              ch_last;
    logic              can_take;
    logic              accept;
    logic              lock_hit;
    logic [SELW-1:0]   lock_ch;
    logic              sel_bad;

    // Only the locked channel is ever looked at; active_ch is always < N_CH.
    assign ch_data  = bus.in_data[active_ch*WIDTH +: WIDTH];
    assign ch_valid = bus.in_valid[active_ch];
    assign ch_last  = bus.in_last[active_ch];

    // The output register can take a beat when empty or draining this cycle.
    assign can_take = (state == LOCKED) && (!out_valid_r || bus.out_ready);
    assign accept   = can_take && ch_valid;

    always_comb begin
        bus.in_ready = '0;
        if (can_take) begin
            bus.in_ready[active_ch] = 1'b1;
        end
    end

`ifdef STREAM_MUX_RR_ARB_EN
    // Search starts one past the previously granted channel.
    logic [SELW-1:0] rr_base;
    logic            unused_sel;

    assign unused_sel = ^bus.sel;
    assign sel_bad    = 1'b0;

    always_comb begin
        lock_hit = 1'b0;
        lock_ch  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!lock_hit && bus.in_valid[(int'(rr_base) + i) % N_CH]) begin
                lock_hit = 1'b1;
                lock_ch  = SELW'((int'(rr_base) + i) % N_CH);
            end
        end
    end
`else
    // The in-range guard keeps an out-of-range sel from indexing in_valid.
    assign sel_bad  = (int'(bus.sel) >= N_CH);
    assign lock_hit = !sel_bad && bus.in_valid[bus.sel];
    assign lock_ch  = bus.sel;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            active_ch   <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            sel_err_r   <= 1'b0;
`ifdef STREAM_MUX_RR_ARB_EN
            rr_base     <= '0;
`endif
        end else begin
            sel_err_r <= 1'b0;
            case (state)
                IDLE: begin
                    sel_err_r <= sel_bad;
                    if (lock_hit) begin
                        active_ch <= lock_ch;
                        state     <= LOCKED;
`ifdef STREAM_MUX_RR_ARB_EN
                        rr_base   <= (int'(lock_ch) == N_CH - 1) ? '0 : lock_ch + 1'b1;
`endif
                    end
                end
                LOCKED: begin
                    // Unlock right after the last beat; the next lock needs one IDLE cycle.
                    if (accept && ch_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                out_data_r  <= ch_data;
                out_last_r  <= ch_last;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.active_ch = active_ch;
    assign bus.busy      = (state == LOCKED);
    assign bus.sel_err   = sel_err_r;
endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n with a scoreboard on the output stream.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A second 5-channel instance exercises out-of-range sel (sel=5, SELW=3).
module tb_stream_mux_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [8:0] sb[$];
    int         out_cyc[$];

    stream_mux_n_if #(.N_CH(4), .WIDTH(8)) m ();
    stream_mux_n_if #(.N_CH(5), .WIDTH(8)) m5 ();

    stream_mux_n #(.N_CH(4), .WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(m));
    stream_mux_n #(.N_CH(5), .WIDTH(8)) dut5 (.clk(clk), .rst(rst), .bus(m5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every transferred beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && m.out_valid && m.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {23'd0, m.out_last, m.out_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("out_data", m.out_data, e[7:0]);
                check("out_last", m.out_last, e[8]);
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic drive(input int ch, input logic [7:0] d, input logic l);
        m.in_data[ch*8 +: 8] = d;
        m.in_last[ch]        = l;
        m.in_valid[ch]       = 1'b1;
        sb.push_back({l, d});
    endtask

    task automatic wait_acc(input int ch);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            @(negedge clk);
            ok = m.in_ready[ch];
            n++;
        end
        check("accept_seen", ok, 1);
        @(posedge clk);
        #1;
        m.in_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        m.sel = '0;        m.in_data = '0;  m.in_valid = '0;  m.in_last = '0;  m.out_ready = 1'b1;
        m5.sel = 3'd5;     m5.in_data = '0; m5.in_valid = '0; m5.in_last = '0; m5.out_ready = 1'b1;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", m.out_valid, 0);
        check("rst_out_data",  m.out_data, 0);
        check("rst_out_last",  m.out_last, 0);
        check("rst_in_ready",  m.in_ready, 0);
        check("rst_active_ch", m.active_ch, 0);
        check("rst_busy",      m.busy, 0);
        check("rst_sel_err",   m.sel_err, 0);
        check("rst_sel_err5",  m5.sel_err, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // 3-beat packet on ch2: 2-cycle first latency, then back-to-back
        out_cyc.delete();
        m.sel = 2'd2;
        c0 = cyc;
        drive(2, 8'hA1, 1'b0); wait_acc(2);
        check("busy_mid", m.busy, 1);
        drive(2, 8'hA2, 1'b0); wait_acc(2);
        drive(2, 8'hA3, 1'b1); wait_acc(2);
        check("busy_after_last", m.busy, 0);
        drain();
        check("out_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3) begin
            check("first_latency", out_cyc[0] - c0, 2);
            check("beat2_gap", out_cyc[1] - out_cyc[0], 1);
            check("beat3_gap", out_cyc[2] - out_cyc[1], 1);
        end

        // Lock on ch1, sel moves to 3 mid-packet while ch3 is valid
        m.sel = 2'd1;
        drive(1, 8'h11, 1'b0); wait_acc(1);
        m.sel = 2'd3;
        m.in_data[24 +: 8] = 8'hC1; m.in_last[3] = 1'b1; m.in_valid[3] = 1'b1;
        check("lock_kept", m.active_ch, 1);
        check("ch3_blocked_a", m.in_ready[3], 0);
        drive(1, 8'h12, 1'b0); wait_acc(1);
        check("ch3_blocked_b", m.in_ready[3], 0);
        check("lock_kept2", m.active_ch, 1);
        drive(1, 8'h13, 1'b1); wait_acc(1);
        check("idle_gap_busy", m.busy, 0);
        check("idle_gap_ready", m.in_ready, 0);
        sb.push_back({1'b1, 8'hC1});
        wait_acc(3);
        check("ch3_locked", m.active_ch, 3);
        drain();

        // Backpressure: out_ready low for 5 cycles mid-packet
        m.sel = 2'd0;
        drive(0, 8'hB1, 1'b0); wait_acc(0);
        m.out_ready = 1'b0;
        drive(0, 8'hB2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_data",  m.out_data, 8'hB1);
            check("stall_valid", m.out_valid, 1);
            check("stall_ready", m.in_ready, 0);
        end
        @(posedge clk); #1 m.out_ready = 1'b1;
        wait_acc(0);
        drive(0, 8'hB3, 1'b0); wait_acc(0);
        drive(0, 8'hB4, 1'b1); wait_acc(0);
        drain();

        // Out-of-range sel on the 5-channel instance
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
`ifdef STREAM_MUX_RR_ARB_EN
            check("sel_err5", m5.sel_err, 0);
`else
            check("sel_err5", m5.sel_err, 1);
`endif
            check("sel_err5_ready", m5.in_ready, 0);
            check("sel_err5_valid", m5.out_valid, 0);
        end
        @(posedge clk); #1 m5.sel = 3'd0;
        @(posedge clk); @(negedge clk);
        check("sel_err5_clear", m5.sel_err, 0);

        // Asynchronous reset mid-packet, then a fresh single-beat packet
        m.sel = 2'd2;
        drive(2, 8'hD1, 1'b0); wait_acc(2);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", m.out_valid, 0);
        check("arst_out_data",  m.out_data, 0);
        check("arst_busy",      m.busy, 0);
        check("arst_in_ready",  m.in_ready, 0);
        check("arst_active_ch", m.active_ch, 0);
        sb.delete();
        m.in_valid = '0;
        @(posedge clk); #1 rst = 1'b0;
        m.sel = 2'd0;
        drive(0, 8'h55, 1'b1); wait_acc(0);
        check("single_beat_unlock", m.busy, 0);
        drain();

`ifdef STREAM_MUX_RR_ARB_EN
        // Round-robin: all channels valid with 1-beat packets -> grants 0,1,2,3,0
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 4; k++) m.in_data[k*8 +: 8] = 8'h20 + 8'(k);
        m.in_last  = 4'hF;
        m.in_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            int  n;
            bit  ok;
            logic [3:0] expg;
            expg = 4'(1 << (g % 4));
            sb.push_back({1'b1, 8'h20 + 8'(g % 4)});
            m.sel = 2'($urandom_range(0, 3));
            n  = 0;
            ok = 1'b0;
            while (n < 20 && !ok) begin
                @(negedge clk);
                ok = (m.in_ready != 4'd0);
                n++;
            end
            check("rr_grant", m.in_ready, expg);
            @(posedge clk); #1;
            if (g == 4) m.in_valid = '0;
        end
        drain();
`endif

        @(posedge clk); @(negedge clk);
        check("final_out_valid", m.out_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
